// File: rtl/cvxif_relu_responder.sv
// CV-X-IF coprocessor responder for the ReLU custom-1 instruction.
// Accepted instructions wait in an in-order buffer until the core commits or kills them.
module cvxif_relu_responder #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic                issue_rs1_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_we_o
);

  localparam int unsigned     PTR_W       = $clog2(DEPTH);
  localparam logic [6:0]      OPCODE_RELU = 7'b0101011;
  localparam logic [PTR_W:0]  FULL_CNT    = (PTR_W+1)'(DEPTH);

  logic [ID_WIDTH-1:0] id_q   [DEPTH];
  logic [4:0]          rd_q   [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] committed_q, committed_d;
  logic [DEPTH-1:0] killed_q, killed_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic match, push, pop, head_kill;
  logic instr_unused;

  assign instr_unused = ^issue_instr_i[31:12];

  assign match             = (issue_instr_i[6:0] == OPCODE_RELU);
  assign issue_accept_o    = match;
  assign issue_writeback_o = match;
  // Readiness looks only at registered occupancy; a same-cycle pop never frees a slot early.
  assign issue_ready_o     = issue_rs1_valid_i && (count_q < FULL_CNT);
  assign push              = issue_valid_i && issue_ready_o && match;

  assign head_kill      = valid_q[head_q] && killed_q[head_q];
  assign result_valid_o = valid_q[head_q] && committed_q[head_q] && !killed_q[head_q];
  assign result_we_o    = result_valid_o;
  assign result_id_o    = result_valid_o ? id_q[head_q]   : '0;
  assign result_rd_o    = result_valid_o ? rd_q[head_q]   : '0;
  assign result_data_o  = result_valid_o ? data_q[head_q] : '0;
  assign pop            = head_kill || (result_valid_o && result_ready_i);

  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    if (commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (id_q[i] == commit_id_i)) begin
          if (commit_kill_i) killed_d[i]    = 1'b1;
          else               committed_d[i] = 1'b1;
        end
      end
    end
    if (pop) valid_d[head_q] = 1'b0;
    // The tail slot is never valid when a push is allowed, so a same-cycle commit cannot touch it.
    if (push) begin
      valid_d[tail_q]     = 1'b1;
      committed_d[tail_q] = 1'b0;
      killed_d[tail_q]    = 1'b0;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
    end
  end

  // NOTE: payload storage is not reset; the valid flags alone decide whether a slot means anything.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[tail_q]   <= issue_id_i;
      rd_q[tail_q]   <= issue_instr_i[11:7];
      data_q[tail_q] <= issue_rs1_i[XLEN-1] ? '0 : issue_rs1_i;
    end
  end

endmodule

// File: tb/tb_cvxif_relu_responder.sv
// Self-checking bench for cvxif_relu_responder: directed scenarios plus a random phase,
// all outputs compared every cycle against a queue-based model of the responder.
module tb_cvxif_relu_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_id_i;
  logic [63:0] issue_rs1_i;
  logic        issue_rs1_valid_i;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        commit_valid_i;
  logic [2:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [2:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [63:0] result_data_o;
  logic        result_we_o;

  int total = 0;
  int bad   = 0;
  bit model_on = 1'b0;

  typedef struct {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [63:0] data;
    bit          committed;
    bit          killed;
  } ent_t;

  ent_t mq[$];

  cvxif_relu_responder dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs1_valid_i (issue_rs1_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_rd_o       (result_rd_o),
    .result_data_o     (result_data_o),
    .result_we_o       (result_we_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] relu(input logic [63:0] v);
    return ($signed(v) < 0) ? 64'd0 : v;
  endfunction

  // Model: outputs come from the queue head, state updates use the inputs held through this cycle.
  always @(negedge clk) begin
    bit          exp_ready, exp_rv, do_pop, exp_acc;
    if (model_on) begin
      exp_ready = issue_rs1_valid_i && (mq.size() < DEPTH);
      exp_acc   = (issue_instr_i[6:0] == 7'h2B);
      check("m_issue_ready", issue_ready_o, exp_ready);
      if (issue_valid_i) begin
        check("m_accept", issue_accept_o, exp_acc);
        check("m_writeback", issue_writeback_o, exp_acc);
      end
      exp_rv = 1'b0;
      do_pop = 1'b0;
      if (mq.size() > 0) begin
        if (mq[0].killed) do_pop = 1'b1;
        else if (mq[0].committed) begin
          exp_rv = 1'b1;
          do_pop = result_ready_i;
        end
      end
      check("m_result_valid", result_valid_o, exp_rv);
      check("m_result_we", result_we_o, exp_rv);
      if (exp_rv) begin
        check("m_result_id", result_id_o, mq[0].id);
        check("m_result_rd", result_rd_o, mq[0].rd);
        check("m_result_data", result_data_o, mq[0].data);
      end
      if (rst_i) mq.delete();
      else begin
        if (commit_valid_i)
          foreach (mq[k])
            if (mq[k].id == commit_id_i) begin
              if (commit_kill_i) mq[k].killed = 1'b1;
              else               mq[k].committed = 1'b1;
            end
        if (do_pop) void'(mq.pop_front());
        if (issue_valid_i && exp_ready && exp_acc)
          mq.push_back('{id: issue_id_i, rd: issue_instr_i[11:7],
                         data: relu(issue_rs1_i), committed: 1'b0, killed: 1'b0});
      end
    end
  end

  task automatic to_mid();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i     = 1'b0;
    issue_instr_i     = 32'h0;
    issue_id_i        = 3'd0;
    issue_rs1_i       = 64'd0;
    issue_rs1_valid_i = 1'b1;
    commit_valid_i    = 1'b0;
    commit_id_i       = 3'd0;
    commit_kill_i     = 1'b0;
  endtask

  task automatic set_issue(input logic [2:0] id, input logic [4:0] rd, input logic [63:0] rs1);
    issue_valid_i = 1'b1;
    issue_instr_i = {20'h0, rd, 7'h2B};
    issue_id_i    = id;
    issue_rs1_i   = rs1;
  endtask

  task automatic set_commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  initial begin
    rst_i = 1'b1;
    result_ready_i = 1'b0;
    idle();
    to_next();
    to_next();
    rst_i = 1'b0;
    model_on = 1'b1;

    // Reset state
    to_mid();
    check("rst_valid", result_valid_o, 1'b0);
    check("rst_id", result_id_o, 3'd0);
    check("rst_rd", result_rd_o, 5'd0);
    check("rst_data", result_data_o, 64'd0);
    check("rst_we", result_we_o, 1'b0);
    check("rst_ready", issue_ready_o, 1'b1);
    to_next();

    // Positive ReLU, earliest result latency
    issue_valid_i = 1'b1; issue_instr_i = 32'h0000_05AB; issue_id_i = 3'd2; issue_rs1_i = 64'd7;
    to_mid();
    check("t1_accept", issue_accept_o, 1'b1);
    check("t1_ready", issue_ready_o, 1'b1);
    to_next();
    idle(); set_commit(3'd2, 1'b0);
    to_mid();
    check("t1_no_early", result_valid_o, 1'b0);
    to_next();
    idle(); result_ready_i = 1'b1;
    to_mid();
    check("t1_valid", result_valid_o, 1'b1);
    check("t1_id", result_id_o, 3'd2);
    check("t1_rd", result_rd_o, 5'd11);
    check("t1_data", result_data_o, 64'd7);
    check("t1_we", result_we_o, 1'b1);
    to_next();
    to_mid();
    check("t1_gone", result_valid_o, 1'b0);
    to_next();

    // Negative and most-negative operands
    set_issue(3'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFF9);
    to_next();
    set_issue(3'd4, 5'd6, 64'h8000_0000_0000_0000); set_commit(3'd3, 1'b0);
    to_next();
    idle(); set_commit(3'd4, 1'b0);
    to_mid();
    check("t2_a_id", result_id_o, 3'd3);
    check("t2_a_rd", result_rd_o, 5'd5);
    check("t2_a_data", result_data_o, 64'd0);
    to_next();
    idle();
    to_mid();
    check("t2_b_valid", result_valid_o, 1'b1);
    check("t2_b_id", result_id_o, 3'd4);
    check("t2_b_data", result_data_o, 64'd0);
    to_next();

    // Reject of a non-custom opcode
    issue_valid_i = 1'b1; issue_instr_i = 32'h0000_0033; issue_id_i = 3'd5; issue_rs1_i = 64'd9;
    to_mid();
    check("t3_accept", issue_accept_o, 1'b0);
    check("t3_wb", issue_writeback_o, 1'b0);
    check("t3_ready", issue_ready_o, 1'b1);
    to_next();
    idle(); set_commit(3'd5, 1'b0);
    to_next();
    idle();
    for (int c = 0; c < 3; c++) begin
      to_mid();
      check("t3_no_result", result_valid_o, 1'b0);
      to_next();
    end

    // Kill and backpressure
    result_ready_i = 1'b0;
    set_issue(3'd0, 5'd1, 64'd100); to_next();
    set_issue(3'd1, 5'd2, 64'd200); to_next();
    set_issue(3'd2, 5'd3, 64'd300); to_next();
    idle(); set_commit(3'd0, 1'b0); to_next();
    idle(); set_commit(3'd1, 1'b1);
    to_mid(); check("t4_hold0_id", result_id_o, 3'd0); to_next();
    idle(); set_commit(3'd2, 1'b0);
    to_mid(); check("t4_hold1_data", result_data_o, 64'd100); to_next();
    idle();
    to_mid(); check("t4_hold2_valid", result_valid_o, 1'b1); to_next();
    result_ready_i = 1'b1;
    to_mid(); check("t4_take0_id", result_id_o, 3'd0); to_next();
    to_mid(); check("t4_drop1", result_valid_o, 1'b0); to_next();
    to_mid();
    check("t4_take2_id", result_id_o, 3'd2);
    check("t4_take2_data", result_data_o, 64'd300);
    to_next();
    to_mid(); check("t4_empty", result_valid_o, 1'b0); to_next();

    // Full buffer, no same-cycle bypass
    for (int i = 0; i < 4; i++) begin
      set_issue(3'(i), 5'(i + 8), 64'(i + 1));
      to_next();
    end
    set_issue(3'd4, 5'd12, 64'd5);
    to_mid(); check("t5_full", issue_ready_o, 1'b0); to_next();
    idle(); set_commit(3'd0, 1'b0); to_next();
    idle();
    to_mid();
    check("t5_pop_valid", result_valid_o, 1'b1);
    check("t5_no_bypass", issue_ready_o, 1'b0);
    to_next();
    to_mid(); check("t5_ready_back", issue_ready_o, 1'b1); to_next();

    // Reset while entries are pending
    result_ready_i = 1'b0;
    set_commit(3'd1, 1'b0); to_next();
    idle(); rst_i = 1'b1;
    to_mid(); check("t6_pre_rst", result_valid_o, 1'b1); to_next();
    rst_i = 1'b0;
    to_mid();
    check("t6_valid", result_valid_o, 1'b0);
    check("t6_id", result_id_o, 3'd0);
    check("t6_ready", issue_ready_o, 1'b1);
    to_next();
    result_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      set_commit(3'(i), 1'b0);
      to_mid(); check("t6_stale", result_valid_o, 1'b0); to_next();
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      to_mid(); check("t6_stale_tail", result_valid_o, 1'b0); to_next();
    end

    // Random phase, checked by the model only
    for (int c = 0; c < 600; c++) begin
      rst_i             = ($urandom_range(0, 99) == 0);
      issue_valid_i     = ($urandom_range(0, 9) < 6);
      issue_rs1_valid_i = ($urandom_range(0, 9) != 0);
      issue_id_i        = 3'($urandom);
      issue_rs1_i       = {$urandom, $urandom};
      issue_instr_i     = $urandom;
      if ($urandom_range(0, 99) < 85) issue_instr_i[6:0] = 7'h2B;
      else if (issue_instr_i[6:0] == 7'h2B) issue_instr_i[0] = 1'b0;
      commit_valid_i    = ($urandom_range(0, 1) == 1);
      commit_id_i       = 3'($urandom);
      commit_kill_i     = ($urandom_range(0, 3) == 0);
      result_ready_i    = ($urandom_range(0, 9) < 7);
      to_next();
    end
    rst_i = 1'b0;
    idle();
    to_next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cvxif_relu_responder.md
Name: cvxif_relu_responder

Overview:
- Coprocessor-side responder for the CV-X-IF interface. It executes the ReLU custom instruction (opcode 7'b0101011, custom-1) that the core offloads.
- It decodes each issue request, computes ReLU on rs1, and holds the result in an in-order pending buffer until the core commits or kills the instruction.
- It returns committed results over the result handshake.
- It sits between the CVA6 CV-X-IF master ports and the writeback path of the example coprocessor.

Parameters:
- XLEN, 64, register/data width in bits.
- ID_WIDTH, 3, instruction ID width in bits.
- DEPTH, 4, pending-buffer entries; must be a power of 2, minimum 2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- issue_valid_i  input  1  core presents an issue request.
- issue_ready_o  output  1  responder can take an issue request.
- issue_instr_i  input  32  offloaded instruction word.
- issue_id_i  input  ID_WIDTH  instruction ID.
- issue_rs1_i  input  XLEN  rs1 operand.
- issue_rs1_valid_i  input  1  rs1 operand is valid.
- issue_accept_o  output  1  instruction is accepted as a coprocessor instruction.
- issue_writeback_o  output  1  instruction will write rd.
- commit_valid_i  input  1  commit message valid.
- commit_id_i  input  ID_WIDTH  ID being committed or killed.
- commit_kill_i  input  1  1 = kill, 0 = commit.
- result_valid_o  output  1  result available.
- result_ready_i  input  1  core takes the result.
- result_id_o  output  ID_WIDTH  ID of the result.
- result_rd_o  output  5  destination register (instr[11:7]).
- result_data_o  output  XLEN  ReLU value.
- result_we_o  output  1  write enable; 1 whenever result_valid_o is 1.

Behaviour:
- Decode (combinational):
  - match = (issue_instr_i[6:0] == 7'b0101011).
  - issue_accept_o = issue_writeback_o = match; both are driven whenever issue_valid_i is high.
- Issue handshake:
  - issue_ready_o = issue_rs1_valid_i && (count < DEPTH).
  - count is the registered occupancy. There is no same-cycle bypass: when full, issue_ready_o is 0 even if the head pops this cycle.
  - A transfer happens when issue_valid_i && issue_ready_o.
  - A transfer with match=0 is a reject: nothing is stored and the responder stays idle for that ID.
  - A transfer with match=1 pushes entry {id, rd, data, committed=0, killed=0} at the tail.
  - data = issue_rs1_i[XLEN-1] ? 0 : issue_rs1_i, i.e. a signed compare; the most-negative value gives 0.
- Commit:
  - When commit_valid_i is high, every valid entry whose id equals commit_id_i gets committed<=1 (kill=0) or killed<=1 (kill=1). Flags register on the next edge.
  - A commit for an ID not present in the buffer is ignored.
  - A commit whose ID is being pushed in the same cycle does not affect the new entry; the protocol guarantees commit comes after issue.
- Result / pop:
  - Head state is evaluated every cycle:
    - head valid && killed: pop silently; result_valid_o stays 0 that cycle.
    - head valid && committed && !killed: result_valid_o=1, and result_id_o, result_rd_o, result_data_o reflect the head.
    - head uncommitted: result_valid_o=0.
  - The head pops on result_valid_o && result_ready_i.
  - While result_valid_o is high and result_ready_i is low, all result_* outputs stay stable.
  - At most one pop per cycle, so results leave in issue order.
- Latency: issue accepted at cycle N, earliest commit at N+1, earliest result_valid_o at N+2 (empty buffer, commit present at N+1).
- Occupancy: push and pop in the same cycle leave count unchanged. Pointers are log2(DEPTH) bits and wrap naturally.
- Reset: synchronous on rst_i, including mid-operation.
  - count, pointers and all entry valid/committed/killed flags clear to 0.
  - result_valid_o=0, result_id_o=0, result_rd_o=0, result_data_o=0, result_we_o=0.
  - issue_ready_o follows issue_rs1_valid_i on the cycle after reset.
  - Pending entries are discarded without producing a result.

Test Plan:
- ReLU positive, XLEN=64: issue id=2, instr=0x0000_05AB (rd=11), rs1=0x0000_0000_0000_0007, then commit id=2 kill=0 at the next cycle -> result_valid_o at issue+2 with id=2, rd=11, data=7, we=1.
- ReLU negative and most-negative: rs1=0xFFFF_FFFF_FFFF_FFF9 and rs1=0x8000_0000_0000_0000, each committed -> data=0 for both, delivered in issue order.
- Reject: instr=0x0000_0033 (OP opcode), issue_valid_i=1 -> issue_accept_o=0, issue_writeback_o=0, handshake completes, count stays 0, and no result follows a later commit of that ID.
- Kill and backpressure: issue ids 0,1,2; kill id 1; commit ids 0 and 2; hold result_ready_i=0 for 3 cycles -> id 0 held stable for 3 cycles; after ready rises, id 1 is dropped silently and id 2 follows.
- Full: issue 4 ReLU with no commits -> issue_ready_o=0 on the 5th request; commit id of the head and accept the result -> issue_ready_o returns to 1 on the following cycle.
- Reset mid-operation: 3 entries pending, 1 committed with result_ready_i=0, assert rst_i for 1 cycle -> result_valid_o=0, count=0, and later commits of the old IDs produce no results.
